// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one imem read per instruction,
// presents the word to decode and waits for writeback to commit the next PC.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        ifu_valid,
  output logic [31:0] real_ins,
  input  logic        idu_ready,
  output logic [31:0] pc,
  input  logic        pc_update_valid,
  input  logic [31:0] next_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_RESP_ERR  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'd2;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'd3;

  logic [2:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] ins_r, ins_s;
  logic [1:0]  cause_r, cause_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        req_valid_r;
  logic        ifu_valid_r;
  logic        fault_r;

  // Next-state and datapath decode for the single-instruction-in-flight FSM
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ins_s   = ins_r;
    cause_s = cause_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_REQ: begin
        if (imem_req_ready) begin
          state_s = S_WAIT;
          cnt_s   = 8'd0;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        // a response in the final counted cycle still beats the timeout
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            cause_s = CAUSE_RESP_ERR;
            state_s = S_FAULT;
          end else begin
            ins_s   = imem_resp_data;
            state_s = S_HOLD;
          end
        end else if (cnt_r == TIMEOUT_LAST) begin
          cause_s = CAUSE_TIMEOUT;
          state_s = S_FAULT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_HOLD: begin
        if (idu_ready) begin
          state_s = S_EXEC;
        end else begin
          state_s = S_HOLD;
        end
      end
      S_EXEC: begin
        if (pc_update_valid) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_s    = next_pc;
            state_s = S_REQ;
          end else begin
            cause_s = CAUSE_MISALIGN;
            state_s = S_FAULT;
          end
        end else begin
          state_s = S_EXEC;
        end
      end
      S_FAULT: begin
        state_s = S_FAULT;
      end
      default: begin
        state_s = S_FAULT;
      end
    endcase
  end

  // State, datapath and decoded output flags, with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      ins_r       <= 32'd0;
      cause_r     <= 2'd0;
      cnt_r       <= 8'd0;
      req_valid_r <= 1'b1;
      ifu_valid_r <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ins_r       <= ins_s;
      cause_r     <= cause_s;
      cnt_r       <= cnt_s;
      req_valid_r <= (state_s == S_REQ);
      ifu_valid_r <= (state_s == S_HOLD);
      fault_r     <= (state_s == S_FAULT);
    end
  end

  assign imem_req_valid = req_valid_r & ~rst;
  assign imem_req_addr  = pc_r;
  assign ifu_valid      = ifu_valid_r & ~rst;
  assign real_ins       = ins_r;
  assign pc             = pc_r;
  assign fetch_fault    = fault_r;
  assign fault_cause    = cause_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a main instance (TIMEOUT=255) plus a
// TIMEOUT=4 instance sharing the same stimulus for the timeout scenarios.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready, imem_resp_valid, imem_resp_err;
  logic        idu_ready, pc_update_valid;
  logic [31:0] imem_resp_data, next_pc;

  logic        imem_req_valid, ifu_valid, fetch_fault;
  logic [31:0] imem_req_addr, real_ins, pc;
  logic [1:0]  fault_cause;

  logic        t_imem_req_valid, t_ifu_valid, t_fetch_fault;
  logic [31:0] t_imem_req_addr, t_real_ins, t_pc;
  logic [1:0]  t_fault_cause;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .ifu_valid(ifu_valid), .real_ins(real_ins), .idu_ready(idu_ready),
    .pc(pc), .pc_update_valid(pc_update_valid), .next_pc(next_pc),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .imem_req_valid(t_imem_req_valid), .imem_req_addr(t_imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .ifu_valid(t_ifu_valid), .real_ins(t_real_ins), .idu_ready(idu_ready),
    .pc(t_pc), .pc_update_valid(pc_update_valid), .next_pc(next_pc),
    .fetch_fault(t_fetch_fault), .fault_cause(t_fault_cause)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string tag);
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    imem_resp_data = 32'd0; idu_ready = 1'b0; pc_update_valid = 1'b0; next_pc = 32'd0;
    exp_q.delete();
    tick(); tick();
    vectors++;
    if (imem_req_valid !== 1'b0 || ifu_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_in_reset: req_valid=%b ifu_valid=%b want 0 0", tag, imem_req_valid, ifu_valid);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || pc !== RST_PC || ifu_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_release: req_valid=%b addr=%h pc=%h ifu_valid=%b want 1 %h %h 0",
               tag, imem_req_valid, imem_req_addr, pc, ifu_valid, RST_PC, RST_PC);
    end
    vectors++;
    if (real_ins !== 32'd0 || fetch_fault !== 1'b0 || fault_cause !== 2'd0 || t_fetch_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_regs: real_ins=%h fault=%b cause=%0d t_fault=%b want 0 0 0 0",
               tag, real_ins, fetch_fault, fault_cause, t_fetch_fault);
    end
  endtask

  task automatic serve_fetch(input logic [31:0] addr, input logic [31:0] word,
                             input int rdy_dly, input int rsp_dly, input string tag);
    logic [63:0] exp;
    for (int i = 0; i <= rdy_dly; i++) begin
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== addr) begin
        miscompares++;
        $display("FAIL %s_req: valid=%b addr=%h want 1 %h", tag, imem_req_valid, imem_req_addr, addr);
      end
      if (i < rdy_dly) tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      vectors++;
      if (imem_req_valid !== 1'b0 || ifu_valid !== 1'b0 || fetch_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_wait: req_valid=%b ifu_valid=%b fault=%b want 0 0 0",
                 tag, imem_req_valid, ifu_valid, fetch_fault);
      end
      tick();
    end
    imem_resp_valid = 1'b1; imem_resp_data = word; imem_resp_err = 1'b0;
    exp_q.push_back({addr, word});
    tick();
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_scoreboard: queue empty, want one entry", tag);
    end else begin
      exp = exp_q.pop_front();
      if (ifu_valid !== 1'b1 || real_ins !== exp[31:0] || pc !== exp[63:32] || fetch_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_deliver: ifu_valid=%b ins=%h pc=%h fault=%b want 1 %h %h 0",
                 tag, ifu_valid, real_ins, pc, fetch_fault, exp[31:0], exp[63:32]);
      end
    end
  endtask

  task automatic hold_accept(input logic [31:0] exp_pc, input logic [31:0] exp_ins,
                             input int stall, input int pulse_at, input string tag);
    idu_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (i == pulse_at) begin
        pc_update_valid = 1'b1;
        next_pc = 32'h8000_0004;
      end
      tick();
      pc_update_valid = 1'b0;
      vectors++;
      if (ifu_valid !== 1'b1 || real_ins !== exp_ins || pc !== exp_pc || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_stall%0d: ifu_valid=%b ins=%h pc=%h req=%b want 1 %h %h 0",
                 tag, i, ifu_valid, real_ins, pc, imem_req_valid, exp_ins, exp_pc);
      end
    end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    vectors++;
    if (ifu_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== exp_pc) begin
      miscompares++;
      $display("FAIL %s_accept: ifu_valid=%b req=%b pc=%h want 0 0 %h", tag, ifu_valid, imem_req_valid, pc, exp_pc);
    end
  endtask

  task automatic commit(input logic [31:0] npc, input int idle, input string tag);
    for (int i = 0; i < idle; i++) begin
      tick();
      vectors++;
      if (ifu_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_exec_idle: ifu_valid=%b req=%b want 0 0", tag, ifu_valid, imem_req_valid);
      end
    end
    pc_update_valid = 1'b1; next_pc = npc;
    tick();
    pc_update_valid = 1'b0;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== npc || pc !== npc) begin
      miscompares++;
      $display("FAIL %s_commit: req=%b addr=%h pc=%h want 1 %h %h", tag, imem_req_valid, imem_req_addr, pc, npc, npc);
    end
  endtask

  task automatic check_no_requests(input logic want_tdut, input logic [1:0] cause, input string tag);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (want_tdut) begin
        if (t_imem_req_valid !== 1'b0 || t_fetch_fault !== 1'b1 || t_fault_cause !== cause || t_ifu_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_sticky: req=%b fault=%b cause=%0d ifu=%b want 0 1 %0d 0",
                   tag, t_imem_req_valid, t_fetch_fault, t_fault_cause, t_ifu_valid, cause);
        end
      end else begin
        if (imem_req_valid !== 1'b0 || fetch_fault !== 1'b1 || fault_cause !== cause || ifu_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_sticky: req=%b fault=%b cause=%0d ifu=%b want 0 1 %0d 0",
                   tag, imem_req_valid, fetch_fault, fault_cause, ifu_valid, cause);
        end
      end
    end
  endtask

  task automatic test_first_fetch();
    serve_fetch(RST_PC, 32'h0000_0413, 0, 0, "first");
  endtask

  task automatic test_backpressure();
    hold_accept(RST_PC, 32'h0000_0413, 5, 2, "bp");
    commit(32'h8000_0004, 3, "bp");
  endtask

  task automatic test_slow_memory();
    serve_fetch(32'h8000_0004, 32'h00a0_0093, 3, 10, "slow");
    hold_accept(32'h8000_0004, 32'h00a0_0093, 0, -1, "slow");
    commit(32'h8000_0010, 0, "slow");
  endtask

  task automatic test_back_to_back();
    logic [31:0] cur, word;
    cur = 32'h8000_0010;
    for (int i = 0; i < 4; i++) begin
      word = $urandom;
      serve_fetch(cur, word, i % 2, i, "b2b");
      hold_accept(cur, word, i % 3, -1, "b2b");
      cur = cur + 32'd4;
      commit(cur, 0, "b2b");
    end
  endtask

  task automatic test_resp_err();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_err = 1'b1; imem_resp_data = 32'hffff_ffff;
    tick();
    imem_resp_valid = 1'b0; imem_resp_err = 1'b0; imem_resp_data = 32'd0;
    vectors++;
    if (fetch_fault !== 1'b1 || fault_cause !== 2'd1 || ifu_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_err: fault=%b cause=%0d ifu=%b req=%b want 1 1 0 0",
               fetch_fault, fault_cause, ifu_valid, imem_req_valid);
    end
    check_no_requests(1'b0, 2'd1, "resp_err");
  endtask

  task automatic test_timeout();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (i < 3) begin
        if (t_fetch_fault !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_early: wait_cycle=%0d fault=%b want 0", i + 1, t_fetch_fault);
        end
      end else begin
        if (t_fetch_fault !== 1'b1 || t_fault_cause !== 2'd2 || fetch_fault !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_fire: t_fault=%b t_cause=%0d main_fault=%b want 1 2 0",
                   t_fetch_fault, t_fault_cause, fetch_fault);
        end
      end
    end
    check_no_requests(1'b1, 2'd2, "timeout");
  endtask

  task automatic test_timeout_boundary();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick(); tick(); tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0040_0113; imem_resp_err = 1'b0;
    tick();
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    vectors++;
    if (t_ifu_valid !== 1'b1 || t_fetch_fault !== 1'b0 || t_real_ins !== 32'h0040_0113) begin
      miscompares++;
      $display("FAIL timeout_boundary: ifu=%b fault=%b ins=%h want 1 0 00400113",
               t_ifu_valid, t_fetch_fault, t_real_ins);
    end
  endtask

  task automatic test_misaligned();
    serve_fetch(RST_PC, 32'h0000_0013, 0, 0, "misal");
    hold_accept(RST_PC, 32'h0000_0013, 0, -1, "misal");
    pc_update_valid = 1'b1; next_pc = 32'h8000_0002;
    tick();
    pc_update_valid = 1'b0;
    vectors++;
    if (fetch_fault !== 1'b1 || fault_cause !== 2'd3 || pc !== RST_PC || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned: fault=%b cause=%0d pc=%h req=%b want 1 3 %h 0",
               fetch_fault, fault_cause, pc, imem_req_valid, RST_PC);
    end
    check_no_requests(1'b0, 2'd3, "misal");
  endtask

  task automatic test_reset_mid_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0 || ifu_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midwait_rst_high: req=%b ifu=%b want 0 0", imem_req_valid, ifu_valid);
    end
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef; imem_resp_err = 1'b0;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL midwait_fresh_req: req=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
    tick();
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    vectors++;
    if (ifu_valid !== 1'b0 || real_ins !== 32'd0 || imem_req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midwait_stale: ifu=%b ins=%h req=%b want 0 00000000 1", ifu_valid, real_ins, imem_req_valid);
    end
    serve_fetch(RST_PC, 32'h0010_0073, 0, 0, "midwait");
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    imem_resp_data = 32'd0; idu_ready = 1'b0; pc_update_valid = 1'b0; next_pc = 32'd0;
    test_reset("reset");
    test_first_fetch();
    test_backpressure();
    test_slow_memory();
    test_back_to_back();
    test_resp_err();
    test_reset("reset_to");
    test_timeout();
    test_reset("reset_bnd");
    test_timeout_boundary();
    test_reset("reset_mis");
    test_misaligned();
    test_reset("reset_mid");
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit for the multicycle core. It is the producer end of the ifu_valid / real_ins → IDU handshake. It holds the architectural PC and issues one word read per instruction on a simple valid/ready instruction-memory port. It presents the fetched word to decode until accepted, then waits for the writeback stage to commit the next PC before fetching again (one instruction in flight).

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, max cycles waiting for an imem response before a fetch fault (8-bit counter; legal range 1..255).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
imem_req_valid  output  1  read request valid.
imem_req_addr  output  32  read address (= pc).
imem_req_ready  input  1  memory accepts request this cycle.
imem_resp_valid  input  1  read data returned this cycle.
imem_resp_data  input  32  instruction word.
imem_resp_err  input  1  access error qualifying imem_resp_valid.
ifu_valid  output  1  real_ins holds a valid instruction for decode.
real_ins  output  32  fetched instruction, registered.
idu_ready  input  1  decode accepts; transfer when ifu_valid && idu_ready.
pc  output  32  PC of the instruction being fetched/presented/executed.
pc_update_valid  input  1  writeback commits next PC (one-cycle pulse).
next_pc  input  32  committed next PC.
fetch_fault  output  1  sticky fault flag.
fault_cause  output  2  0 none, 1 resp error, 2 timeout, 3 misaligned next_pc.

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD, S_EXEC, S_FAULT. All registered; outputs are Moore (decoded from state/registers only).
- Reset (rst=1 at posedge): state=S_REQ, pc=RESET_PC, real_ins=0, fetch_fault=0, fault_cause=0, timeout counter=0. While rst is high, imem_req_valid=0 and ifu_valid=0 are forced. Reset mid-operation discards any in-flight request; a late response is ignored because it arrives in S_REQ.
- S_REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready → S_WAIT, counter=0. imem_resp_valid in S_REQ is ignored.
- S_WAIT: imem_req_valid=0. On imem_resp_valid:
  - err=0: real_ins<=imem_resp_data → S_HOLD.
  - err=1: fault_cause<=1 → S_FAULT.
  - Otherwise counter increments; when counter==TIMEOUT-1 without a response, fault_cause<=2 → S_FAULT.
  - A response arriving in the cycle the counter hits the limit wins over the timeout.
- S_HOLD: ifu_valid=1; real_ins and pc stable. On idu_ready → S_EXEC; ifu_valid low the following cycle. Exactly one transfer per fetch.
- S_EXEC: ifu_valid=0, waiting for writeback. On pc_update_valid:
  - next_pc[1:0]==0: pc<=next_pc → S_REQ. The next request is visible the cycle after the pulse.
  - next_pc[1:0]!=0: fault_cause<=3 → S_FAULT; pc unchanged.
- pc_update_valid outside S_EXEC: ignored, no state or pc change.
- S_FAULT: fetch_fault=1, ifu_valid=0, imem_req_valid=0. Held until rst.
- Minimum fetch latency: request at cycle N, accepted at N, response at N+1, ifu_valid at N+2.
- pc width 32, no arithmetic on pc; the sequential/branch target comes from next_pc.
- No DPI calls; fully synthesizable.

Test Plan:
- Reset release, memory ready/responds immediately with 32'h00000413 → imem_req_valid with addr 32'h8000_0000 the first cycle after reset; ifu_valid=1, real_ins=32'h00000413 two cycles later; pc=32'h8000_0000.
- Backpressure: idu_ready low 5 cycles while ifu_valid=1 → real_ins/pc constant all 5 cycles; single transfer on idu_ready; ifu_valid=0 next cycle; no new imem request before pc_update_valid.
- Commit loop: pc_update_valid with next_pc=32'h8000_0004 in S_EXEC → next cycle imem_req_addr=32'h8000_0004; pulse sent during S_HOLD is ignored, pc stays 32'h8000_0000.
- Slow memory: imem_req_ready delayed 3 cycles, response delayed 10 cycles → request held stable with same addr; correct word delivered; no fault.
- Faults:
  - imem_resp_err=1 → fetch_fault=1, fault_cause=1.
  - No response with TIMEOUT=4 → fault_cause=2 after 4 wait cycles.
  - next_pc=32'h8000_0002 → fault_cause=3.
  - In each case no further requests are issued until rst.
- Reset mid-wait: rst in S_WAIT, stale response arrives the cycle after reset → ignored; fresh request to RESET_PC issued; ifu_valid never shows the stale data.
